pwls_mixer: RTL and testbench
=============================

// Module: pwls_mixer
//
// PURPOSE
//   Output stage directly downstream of pwls_channel_ALU_unit. Sums the signed per-channel
//   samples the channel ALU emits, one sample per channel per frame, into a frame accumulator.
//   On the frame's last sample it scales, saturates and latches the mix as the current output.
//   A first-order delta-sigma modulator turns that output into a 1-bit PDM stream for the pin.
//
// PARAMETERS
//   BITS       12  width of signed channel sample (in_sample)
//   ACC_BITS   14  width of signed frame accumulator (BITS+2: 4 full-scale channels)
//   SHIFT      1   arithmetic right shift applied to the frame sum before saturation
//   OUT_BITS   12  width of signed mixed output; also the DSM resolution
//
// PORTS
//   clk            in   1         system clock
//   reset          in   1         asynchronous, active-high reset
//   in_valid       in   1         in_sample/in_last valid this cycle
//   in_last        in   1         qualifies in_valid: sample is the last of the frame
//   in_sample      in   BITS      signed channel sample from the channel ALU
//   sample_out     out  OUT_BITS  signed mixed sample of the last completed frame
//   sample_strobe  out  1         1-cycle pulse: sample_out/clip updated this cycle
//   clip           out  1         last completed frame saturated (accumulator or output)
//   pdm_out        out  1         delta-sigma bitstream of sample_out
//
// BEHAVIOUR
//   - Reset (async, active-high): acc=0, sample_out=0, sample_strobe=0, clip=0, pdm_out=0,
//     DSM error=0, sticky acc-overflow flag=0. Reset mid-frame discards partial sums.
//   - No backpressure: every cycle with in_valid=1 is accepted. in_last is ignored when in_valid=0.
//   - in_valid & !in_last:
//     - acc <= sat_ACC(acc + sext(in_sample)).
//     - If saturation occurred, set the sticky ovf flag.
//   - in_valid & in_last:
//     - sum = sat_ACC(acc + sext(in_sample)).
//     - scaled = sum >>> SHIFT (floor; -1>>>1 = -1).
//     - Next cycle: sample_out = sat_OUT(scaled), sample_strobe = 1.
//     - clip = ovf | acc-sat this cycle | out-sat.
//     - acc <= 0, ovf <= 0.
//   - A single-sample frame (in_last on the first sample) is legal: result = sat(in_sample >>> SHIFT).
//   - A frame may hold any number of samples; the accumulator saturates and never wraps.
//   - sample_out and clip hold between strobes. sample_strobe is high for exactly one cycle per frame.
//   - Back-to-back frames (in_last on consecutive cycles) each give a strobe on consecutive cycles.
//   - DSM runs every cycle from the current sample_out:
//     - u = sample_out + 2^(OUT_BITS-1), offset binary, unsigned OUT_BITS.
//     - {carry, err} <= err + u; pdm_out <= carry.
//     - Ones density = u / 2^OUT_BITS exactly over any 2^OUT_BITS-cycle window of a held input.
//     - A new sample_out takes effect in the DSM the cycle after the strobe. err is not cleared on update.
//   - All outputs are registered. Latency from the in_last sample to sample_strobe is 1 cycle; to first PDM bit, 2.
//
// STRUCTURE
//   - pwls_pkg:
//     - Saturation helper function (signed, width-parameterised).
//     - Default BITS/OUT_BITS constants shared with the channel ALU.
//   - Sub-module pwls_dsm (first-order delta-sigma; clk, reset, in OUT_BITS signed, out 1 bit).
//     - Instantiated once here; reusable for other output pins.
//   - Accumulator, scale/saturate and output registers live in pwls_mixer itself.
//
// TESTING  (defaults BITS=12, ACC_BITS=14, SHIFT=1, OUT_BITS=12)
//   - Reset:
//     - Assert reset mid-run.
//     - Expect sample_out=0, sample_strobe=0, clip=0, pdm_out=0 immediately (async), held while reset.
//   - Basic mix:
//     - Feed 100, 200, 300, -100 with in_last on the 4th.
//     - Next cycle: sample_out=250, strobe=1 for 1 cycle, clip=0.
//     - in_last with in_valid=0 leaves everything unchanged.
//   - Output saturation:
//     - 4x 2047 -> sample_out=2047, clip=1.
//     - 4x -2048 -> sample_out=-2048, clip=1.
//     - Next frame of single 10 -> 5, clip=0.
//   - Acc saturation:
//     - 5x 2047 -> acc sticks at 8191, sample_out=2047, clip=1.
//     - 5x -2048 then 1 (last): acc=-8192+1 -> -8191>>>1=-4096 -> -2048, clip=1.
//   - PDM density over 4096 cycles of a held input:
//     - sample_out=0 -> 2048 ones, strictly alternating after reset.
//     - sample_out=1024 -> 3072 ones.
//     - sample_out=-2048 -> 0 ones.
//   - Mid-frame reset:
//     - Feed 500, 500, pulse reset, then single-sample frame 10 (last).
//     - Expect sample_out=5 (no residue), plus back-to-back single-sample frames giving consecutive strobes.

Source files
------------

// File: rtl/pwls_pkg.sv
// pwls_pkg: shared widths and signed saturation helper for the pwls output path
package pwls_pkg;
  localparam int DEF_BITS = 12;
  localparam int DEF_OUT_BITS = 12;
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/pwls_dsm.sv
// pwls_dsm: first-order delta-sigma modulator turning a signed sample into a 1-bit stream
module pwls_dsm #(
  parameter int OUT_BITS = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [OUT_BITS-1:0] sample,
  output logic                       pdm
);
  logic [OUT_BITS-1:0] u, err;
  logic [OUT_BITS:0] nxt;
  // offset-binary input added to the running error; the carry is the output bit
  always_comb begin
    u = {~sample[OUT_BITS-1], sample[OUT_BITS-2:0]};
    nxt = {1'b0, err} + {1'b0, u};
  end
  // error accumulator and registered bitstream
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err <= '0;
      pdm <= 1'b0;
    end else begin
      err <= nxt[OUT_BITS-1:0];
      pdm <= nxt[OUT_BITS];
    end
endmodule

// File: rtl/pwls_mixer.sv
// pwls_mixer: sums per-channel samples per frame, scales/saturates the mix, drives a PDM pin
module pwls_mixer
  import pwls_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int ACC_BITS = 14,
  parameter int SHIFT = 1,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic signed [BITS-1:0]     in_sample,
  output logic signed [OUT_BITS-1:0] sample_out,
  output logic                       sample_strobe,
  output logic                       clip,
  output logic                       pdm_out
);
  logic signed [ACC_BITS-1:0] acc;
  logic ovf;
  logic signed [31:0] sum_raw, sum_sat, scaled, out_sat;
  logic acc_hit, out_hit;
  // saturating frame sum, floor-shifted and clamped to the output range
  always_comb begin
    sum_raw = 32'(acc) + 32'(in_sample);
    sum_sat = sat(sum_raw, ACC_BITS);
    acc_hit = sum_sat != sum_raw;
    scaled = sum_sat >>> SHIFT;
    out_sat = sat(scaled, OUT_BITS);
    out_hit = out_sat != scaled;
  end
  // frame accumulator, sticky overflow and registered frame result
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
      sample_out <= '0;
      sample_strobe <= 1'b0;
      clip <= 1'b0;
    end else begin
      sample_strobe <= in_valid & in_last;
      if (in_valid && in_last) begin
        sample_out <= out_sat[OUT_BITS-1:0];
        clip <= ovf | acc_hit | out_hit;
        acc <= '0;
        ovf <= 1'b0;
      end else if (in_valid) begin
        acc <= sum_sat[ACC_BITS-1:0];
        ovf <= ovf | acc_hit;
      end
    end
  pwls_dsm #(.OUT_BITS(OUT_BITS)) u_dsm (
    .clk(clk),
    .reset(reset),
    .sample(sample_out),
    .pdm(pdm_out)
  );
endmodule

// File: tb/tb_pwls_mixer.sv
// tb_pwls_mixer: scoreboard bench for frame mixing, saturation, reset and PDM density
module tb_pwls_mixer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic signed [11:0] in_sample = '0;
  logic signed [11:0] sample_out;
  logic sample_strobe, clip, pdm_out;
  int total = 0;
  int bad = 0;
  logic signed [11:0] exp_s[$];
  logic exp_c[$];

  pwls_mixer dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_sample(in_sample),
    .sample_out(sample_out),
    .sample_strobe(sample_strobe),
    .clip(clip),
    .pdm_out(pdm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic send(input int s, input bit l);
    in_valid = 1'b1;
    in_sample = 12'(s);
    in_last = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic expect_frame(input int s, input bit c);
    exp_s.push_back(12'(s));
    exp_c.push_back(c);
  endtask

  task automatic density(input string name, input int req_ones, input bit alt);
    int ones, breaks;
    logic prev;
    ones = 0;
    breaks = 0;
    prev = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
      if (pdm_out == prev) breaks++;
      prev = pdm_out;
    end
    check(name, ones, req_ones);
    if (alt) check({name, "_alternate_breaks"}, breaks, 0);
  endtask

  initial begin
    logic signed [11:0] s;
    logic c;
    forever begin
      @(negedge clk);
      if (!reset && sample_strobe) begin
        if (exp_s.size() == 0) begin
          check("unexpected_strobe", int'(sample_out), -9999);
        end else begin
          s = exp_s.pop_front();
          c = exp_c.pop_front();
          check("sample_out", int'(sample_out), int'(s));
          check("clip", int'(clip), int'(c));
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_sample_out", int'(sample_out), 0);
    check("rst_strobe", int'(sample_strobe), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_pdm", int'(pdm_out), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    density("pdm_zero_ones", 2048, 1'b1);

    send(100, 0); send(200, 0); send(300, 0);
    expect_frame(250, 0);
    send(-100, 1);
    @(negedge clk);
    @(negedge clk);
    check("strobe_one_cycle", int'(sample_strobe), 0);
    in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_last = 1'b0;
    check("last_no_valid_sample", int'(sample_out), 250);
    check("last_no_valid_clip", int'(clip), 0);

    #3 reset = 1'b1;
    #1;
    check("async_rst_sample_out", int'(sample_out), 0);
    check("async_rst_strobe", int'(sample_strobe), 0);
    check("async_rst_clip", int'(clip), 0);
    check("async_rst_pdm", int'(pdm_out), 0);
    repeat (3) @(posedge clk);
    #1;
    check("held_rst_sample_out", int'(sample_out), 0);
    check("held_rst_pdm", int'(pdm_out), 0);
    reset = 1'b0;

    repeat (3) send(2047, 0);
    expect_frame(2047, 1);
    send(2047, 1);
    repeat (3) send(-2048, 0);
    expect_frame(-2048, 1);
    send(-2048, 1);
    expect_frame(5, 0);
    send(10, 1);

    repeat (4) send(2047, 0);
    expect_frame(2047, 1);
    send(2047, 1);
    repeat (5) send(-2048, 0);
    expect_frame(-2048, 1);
    send(1, 1);

    send(500, 0);
    send(500, 0);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    expect_frame(5, 0);
    send(10, 1);
    expect_frame(5, 0);
    send(10, 1);
    expect_frame(-5, 0);
    send(-10, 1);
    expect_frame(3, 0);
    send(7, 1);

    send(1024, 0);
    expect_frame(1024, 0);
    send(1024, 1);
    @(posedge clk);
    density("pdm_1024_ones", 3072, 1'b0);
    send(-2048, 0);
    expect_frame(-2048, 0);
    send(-2048, 1);
    @(posedge clk);
    density("pdm_neg_full_ones", 0, 1'b0);

    repeat (4) @(posedge clk);
    check("frames_pending", exp_s.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
